blink_scheduler: RTL and testbench

//  Owns the free-running 16-bit phase counter and drives NCH downstream blinker

---
 rtl/blink_scheduler.sv | 120 ++++++++++++
 tb/tb_blink_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_scheduler.sv
// Phase-counter owner and per-channel blink mode sequencer for NCH downstream blinkers.
// Each channel decodes OFF/ON/BLINK/BURST from the shared counter into a blinker count/mask pair.
module blink_scheduler #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [2:0]           cfg_chan,
    input  logic [1:0]           cfg_mode,
    input  logic [3:0]           cfg_rate,
    input  logic [3:0]           cfg_burst,
    output logic [NCH*CW-1:0]    ch_count,
    output logic [NCH*CW-1:0]    ch_mask,
    output logic [NCH-1:0]       blink,
    output logic [NCH-1:0]       busy
);

    localparam int unsigned MW = 2;
    localparam int unsigned RW = 4;
    localparam int unsigned BW = 4;

    localparam logic [MW-1:0] MODE_OFF   = 2'd0;
    localparam logic [MW-1:0] MODE_ON    = 2'd1;
    localparam logic [MW-1:0] MODE_BLINK = 2'd2;
    localparam logic [MW-1:0] MODE_BURST = 2'd3;

    typedef struct packed {
        logic [MW-1:0] mode;
        logic [RW-1:0] rate;
        logic [BW-1:0] remain;
    } chan_t;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          ready_d;
    logic          accept;
    chan_t         ch_q [NCH];
    chan_t         ch_d [NCH];

    // State register: counter, handshake and per-channel mode state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            cfg_ready <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            cfg_ready <= ready_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    // Next-state: falling-edge burst accounting first, then a config write overrides it.
    always_comb begin
        accept  = cfg_valid & cfg_ready;
        cnt_inc = cnt_q + CW'(1);
        cnt_d   = en ? cnt_inc : cnt_q;
        ready_d = ~accept;
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_d[i] = ch_q[i];
            if ((ch_q[i].mode == MODE_BURST) && en &&
                cnt_q[ch_q[i].rate] && !cnt_inc[ch_q[i].rate]) begin
                ch_d[i].remain = ch_q[i].remain - BW'(1);
                if (ch_q[i].remain == BW'(1)) begin
                    ch_d[i].mode = MODE_OFF;
                end
            end
            if (accept && (cfg_chan == 3'(i))) begin
                ch_d[i].rate   = cfg_rate;
                ch_d[i].mode   = cfg_mode;
                ch_d[i].remain = '0;
                if (cfg_mode == MODE_BURST) begin
                    ch_d[i].remain = cfg_burst;
                    // An empty burst never starts.
                    if (cfg_burst == '0) begin
                        ch_d[i].mode = MODE_OFF;
                    end
                end
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        ch_count = '0;
        ch_mask  = '0;
        blink    = '0;
        busy     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            case (ch_q[i].mode)
                MODE_ON: begin
                    ch_count[i*CW +: CW] = CW'(1);
                    ch_mask[i*CW +: CW]  = CW'(1);
                    blink[i]             = 1'b1;
                end
                MODE_BLINK, MODE_BURST: begin
                    ch_count[i*CW +: CW] = cnt_q >> ch_q[i].rate;
                    ch_mask[i*CW +: CW]  = CW'(1);
                    blink[i]             = cnt_q[ch_q[i].rate];
                end
                default: begin
                    ch_count[i*CW +: CW] = '0;
                    ch_mask[i*CW +: CW]  = '0;
                    blink[i]             = 1'b0;
                end
            endcase
            busy[i] = (ch_q[i].mode == MODE_BURST);
        end
    end

endmodule

// File: tb/tb_blink_scheduler.sv
// Scenario bench for blink_scheduler with an arithmetic reference model of counter and channel modes.
module tb_blink_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int BUSW = NCH * CW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [2:0]      cfg_chan = '0;
    logic [1:0]      cfg_mode = '0;
    logic [3:0]      cfg_rate = '0;
    logic [3:0]      cfg_burst = '0;
    logic [BUSW-1:0] ch_count;
    logic [BUSW-1:0] ch_mask;
    logic [NCH-1:0]  blink;
    logic [NCH-1:0]  busy;

    int total = 0;
    int bad = 0;

    // reference model
    int m_cnt = 0;
    int m_mode [NCH];
    int m_rate [NCH];
    int m_remain [NCH];
    bit m_ready = 1'b0;

    blink_scheduler #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode),
        .cfg_rate(cfg_rate), .cfg_burst(cfg_burst),
        .ch_count(ch_count), .ch_mask(ch_mask),
        .blink(blink), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int phase(int c, int r);
        return (c >> r) & 1;
    endfunction

    task automatic model_update();
        bit acc;
        if (rst) begin
            m_cnt = 0;
            m_ready = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 0; m_rate[i] = 0; m_remain[i] = 0;
            end
        end else begin
            acc = cfg_valid && m_ready;
            for (int i = 0; i < NCH; i++) begin
                if (en && m_mode[i] == 3 && phase(m_cnt, m_rate[i]) == 1 &&
                    phase((m_cnt + 1) % 65536, m_rate[i]) == 0) begin
                    m_remain[i] = m_remain[i] - 1;
                    if (m_remain[i] == 0) m_mode[i] = 0;
                end
            end
            if (acc && int'(cfg_chan) < NCH) begin
                m_mode[cfg_chan]   = int'(cfg_mode);
                m_rate[cfg_chan]   = int'(cfg_rate);
                m_remain[cfg_chan] = (cfg_mode == 2'd3) ? int'(cfg_burst) : 0;
                if (cfg_mode == 2'd3 && cfg_burst == 4'd0) m_mode[cfg_chan] = 0;
            end
            m_ready = !acc;
            if (en) m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [BUSW-1:0] exp_count();
        logic [BUSW-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_mode[i] == 1) v[i*CW +: CW] = 16'h0001;
            else if (m_mode[i] >= 2) v[i*CW +: CW] = 16'(m_cnt >> m_rate[i]);
        end
        return v;
    endfunction

    function automatic logic [BUSW-1:0] exp_mask();
        logic [BUSW-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) if (m_mode[i] != 0) v[i*CW +: CW] = 16'h0001;
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_blink();
        logic [NCH-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_mode[i] == 1) v[i] = 1'b1;
            else if (m_mode[i] >= 2) v[i] = 1'(phase(m_cnt, m_rate[i]));
        end
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_busy();
        logic [NCH-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i] = (m_mode[i] == 3);
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({cfg_ready, blink, busy, ch_count, ch_mask} !== '0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got ready=%b blink=%h busy=%h count=%h mask=%h want all zero",
                         k, cfg_ready, blink, busy, ch_count, ch_mask);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if ({cfg_ready, blink, busy, ch_count, ch_mask} !== {1'b1, {(2*NCH+2*BUSW){1'b0}}}) begin
            bad++;
            $display("FAIL reset_release got ready=%b blink=%h busy=%h count=%h mask=%h want ready=1 rest 0",
                     cfg_ready, blink, busy, ch_count, ch_mask);
        end
    endtask

    task automatic test_blink();
        en = 1'b1;
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_mode = 2'd2; cfg_rate = 4'd2; cfg_burst = 4'd0;
        tick();
        cfg_valid = 1'b0;
        total++;
        if (ch_mask[15:0] !== 16'h0001) begin
            bad++;
            $display("FAIL blink_mask got %h want 0001", ch_mask[15:0]);
        end
        for (int k = 0; k < 24; k++) begin
            total++;
            if (blink[0] !== 1'((m_cnt >> 2) & 1) || ch_count[15:0] !== 16'(m_cnt >> 2)) begin
                bad++;
                $display("FAIL blink_phase cnt=%0d got blink=%b count=%h want blink=%0d count=%h",
                         m_cnt, blink[0], ch_count[15:0], (m_cnt >> 2) & 1, 16'(m_cnt >> 2));
            end
            tick();
        end
    endtask

    task automatic test_burst();
        int pulses;
        logic prev;
        bit exp_b;
        do_reset();
        en = 1'b1;
        cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_mode = 2'd3; cfg_rate = 4'd1; cfg_burst = 4'd3;
        tick();
        cfg_valid = 1'b0;
        pulses = 0;
        prev = 1'b0;
        for (int k = 0; k < 18; k++) begin
            // pulses expected while cnt in 2-3, 6-7, 10-11; off from cnt 12
            exp_b = (m_cnt == 2 || m_cnt == 3 || m_cnt == 6 || m_cnt == 7 || m_cnt == 10 || m_cnt == 11);
            total++;
            if (blink[1] !== exp_b || busy[1] !== (m_cnt < 12)) begin
                bad++;
                $display("FAIL burst_seq cnt=%0d got blink=%b busy=%b want blink=%b busy=%b",
                         m_cnt, blink[1], busy[1], exp_b, m_cnt < 12);
            end
            if (blink[1] === 1'b1 && prev === 1'b0) pulses++;
            prev = blink[1];
            tick();
        end
        total++;
        if (pulses != 3 || ch_mask[31:16] !== 16'h0000) begin
            bad++;
            $display("FAIL burst_count got pulses=%0d mask=%h want 3 and 0000", pulses, ch_mask[31:16]);
        end
    endtask

    task automatic test_back_to_back();
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_mode = 2'd1; cfg_rate = 4'd0; cfg_burst = 4'd0;
        tick();
        total++;
        if (cfg_ready !== 1'b0 || blink[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got ready=%b blink0=%b want 0 1", cfg_ready, blink[0]);
        end
        cfg_chan = 3'd2;
        tick();
        total++;
        if (cfg_ready !== 1'b1 || blink[2] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stall got ready=%b blink2=%b want 1 0", cfg_ready, blink[2]);
        end
        tick();
        cfg_valid = 1'b0;
        total++;
        if (cfg_ready !== 1'b0 || blink[2] !== 1'b1 || ch_count[47:32] !== 16'h0001) begin
            bad++;
            $display("FAIL b2b_second got ready=%b blink2=%b count2=%h want 0 1 0001",
                     cfg_ready, blink[2], ch_count[47:32]);
        end
        tick();
    endtask

    task automatic test_freeze_reset();
        int guard;
        en = 1'b1;
        cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_mode = 2'd3; cfg_rate = 4'd3; cfg_burst = 4'd5;
        tick();
        cfg_valid = 1'b0;
        guard = 0;
        while (blink[1] !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 40) begin
            bad++;
            $display("FAIL freeze_wait got blink1=%b want 1 within 40 cycles", blink[1]);
        end
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (blink[1] !== 1'b1 || busy[1] !== 1'b1 || ch_count !== exp_count() || blink !== exp_blink()) begin
                bad++;
                $display("FAIL freeze_hold cyc=%0d got blink=%h busy=%h count=%h want blink=%h busy=%h count=%h",
                         k, blink, busy, ch_count, exp_blink(), exp_busy(), exp_count());
            end
        end
        rst = 1'b1;
        tick();
        total++;
        if (busy !== '0 || blink !== '0 || ch_count !== '0 || cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL freeze_rst got busy=%h blink=%h count=%h ready=%b want 0", busy, blink, ch_count, cfg_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int guard;
        do_reset();
        en = 1'b1;
        while (m_cnt != 16'h7FF0) tick();
        cfg_valid = 1'b1; cfg_chan = 3'd3; cfg_mode = 2'd3; cfg_rate = 4'd15; cfg_burst = 4'd1;
        tick();
        cfg_valid = 1'b0;
        guard = 0;
        while (m_cnt != 0 && guard < 40000) begin
            if (m_cnt == 16'h7FFF || m_cnt == 16'h8000 || m_cnt == 16'hFFFF) begin
                total++;
                if (blink[3] !== (m_cnt >= 16'h8000) || busy[3] !== 1'b1) begin
                    bad++;
                    $display("FAIL wrap_pulse cnt=%h got blink3=%b busy3=%b want %b 1",
                             m_cnt, blink[3], busy[3], m_cnt >= 16'h8000);
                end
            end
            tick();
            guard++;
        end
        total++;
        if (guard >= 40000 || blink[3] !== 1'b0 || busy[3] !== 1'b0 || ch_mask[63:48] !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_end got blink3=%b busy3=%b mask3=%h guard=%0d want 0 0 0000",
                     blink[3], busy[3], ch_mask[63:48], guard);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1200; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 4) != 0);
            cfg_valid = $urandom_range(0, 1);
            cfg_chan  = 3'($urandom_range(0, 7));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_rate  = 4'($urandom_range(0, 4));
            cfg_burst = 4'($urandom_range(0, 15));
            tick();
            total++;
            if ({cfg_ready, blink, busy, ch_count, ch_mask} !==
                {m_ready, exp_blink(), exp_busy(), exp_count(), exp_mask()}) begin
                bad++;
                $display("FAIL random cyc=%0d got ready=%b blink=%h busy=%h count=%h mask=%h want ready=%b blink=%h busy=%h count=%h mask=%h",
                         k, cfg_ready, blink, busy, ch_count, ch_mask,
                         m_ready, exp_blink(), exp_busy(), exp_count(), exp_mask());
            end
        end
        rst = 1'b0; cfg_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = 0; m_rate[i] = 0; m_remain[i] = 0;
        end
        test_reset();
        test_blink();
        test_burst();
        test_back_to_back();
        test_freeze_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
